// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and the data memory.
// Define STBUF_FWD_EN to forward load data from buffered stores instead of stalling on a hit.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk_50,
    input  logic          rst,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wd,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_rvalid,
    output logic          cpu_stall,
    input  logic          flush,
    output logic          empty,
    output logic          MEMRead,
    output logic          MEMWrite,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
`ifdef STBUF_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic          miss_q, miss_d;
    logic [31:0]   fwd_data_q, fwd_data_d;

    logic          hit;
    logic [31:0]   hit_data;
    logic          ld_acc, ld_miss, st_acc, drain;
    logic [PW-1:0] idx;

    // Scan oldest to youngest so the youngest matching word wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[idx][AW-1:2] == cpu_addr[AW-1:2])) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign empty     = (count_q == '0);
    assign cpu_stall = (state_q == FLUSH) | (cpu_rd & hit & ~FWD_EN);
    assign ld_acc    = cpu_rd & ~cpu_stall;
    assign ld_miss   = ld_acc & ~hit;
    assign st_acc    = cpu_wr & ~cpu_rd & ~cpu_stall;
    assign drain     = ~empty & ~ld_miss;

    assign MEMRead    = ld_miss;
    assign MEMWrite   = drain;
    assign mem_addr   = ld_miss ? cpu_addr : addr_q[head_q];
    assign mem_wd     = data_q[head_q];
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = miss_q ? mem_rd : fwd_data_q;

    // Next-state: FIFO pointers, storage, read-return tracking and FSM.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q + CW'(st_acc) - CW'(drain);
        addr_d       = addr_q;
        data_d       = data_q;
        cpu_rvalid_d = ld_acc;
        miss_d       = ld_miss;
        fwd_data_d   = fwd_data_q;
        state_d      = state_q;

        if (drain) begin
            head_d = head_q + PW'(1);
        end
        if (st_acc) begin
            addr_d[tail_q] = cpu_addr;
            data_d[tail_q] = cpu_wd;
            tail_d         = tail_q + PW'(1);
        end
        if (ld_acc && hit) begin
            fwd_data_d = hit_data;
        end

        case (state_q)
            IDLE: begin
                if (st_acc) state_d = DRAIN;
            end
            DRAIN: begin
                if (count_d == '0)  state_d = IDLE;
                else if (flush)     state_d = FLUSH;
            end
            FLUSH: begin
                if (count_d == '0)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            cpu_rvalid_q <= 1'b0;
            miss_q       <= 1'b0;
            fwd_data_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            miss_q       <= miss_d;
            fwd_data_q   <= fwd_data_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, reset sequences and a randomized run
// checked against a queue-based reference model (follows STBUF_FWD_EN if defined).
module tb_store_buffer;
`ifdef STBUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        rd, wr, fl;
        logic [31:0] addr, wd;
        logic        stall, mr, mw;
        logic [31:0] ma, mwd;
        logic        rv;
        logic [31:0] rdat;
        logic        emp;
    } vec_t;

    logic        clk_50, rst;
    logic        cpu_rd, cpu_wr, flush;
    logic [31:0] cpu_addr, cpu_wd, cpu_rdata, mem_addr, mem_wd, mem_rd;
    logic        cpu_rvalid, cpu_stall, empty, MEMRead, MEMWrite;

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk_50(clk_50), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .flush(flush), .empty(empty),
        .MEMRead(MEMRead), .MEMWrite(MEMWrite), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    ent_t        sb[$];
    logic [31:0] gmem [logic [29:0]];
    bit          flushing, prev_ld, last_stall;
    logic [31:0] prev_data;
    int          n_tests, n_fail;
    vec_t        tbl[$];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (gmem.exists(a[31:2])) return gmem[a[31:2]];
        return init_val(a);
    endfunction

    function automatic vec_t mk(input logic rd, wr, fl, input logic [31:0] addr, wd,
                                input logic stall, mr, mw, input logic [31:0] ma, mwd,
                                input logic rv, input logic [31:0] rdat, input logic emp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.fl = fl; v.addr = addr; v.wd = wd;
        v.stall = stall; v.mr = mr; v.mw = mw; v.ma = ma; v.mwd = mwd;
        v.rv = rv; v.rdat = rdat; v.emp = emp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        flushing   = 1'b0;
        prev_ld    = 1'b0;
        last_stall = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rvalid"}, 32'(cpu_rvalid), 32'd0);
        chk({tag, "_rdata"},  cpu_rdata, 32'd0);
        chk({tag, "_empty"},  32'(empty), 32'd1);
        chk({tag, "_mwrite"}, 32'(MEMWrite), 32'd0);
        chk({tag, "_mread"},  32'(MEMRead), 32'd0);
    endtask

    // Drive one cycle of requests, compare at the falling edge, then advance the model.
    task automatic step(input vec_t v, input bit use_tbl);
        bit          hit, e_stall, ld, miss, st, drain;
        int          size_before;
        logic [31:0] hd, e_maddr;
        ent_t        e;
        @(posedge clk_50); #1;
        cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wd = v.wd; flush = v.fl;
        @(negedge clk_50);

        hit = 1'b0; hd = '0;
        foreach (sb[i]) if (sb[i].addr[31:2] == v.addr[31:2]) begin hit = 1'b1; hd = sb[i].data; end
        e_stall = flushing || (v.rd && hit && !FWD);
        ld      = v.rd && !e_stall;
        miss    = ld && !hit;
        st      = v.wr && !v.rd && !e_stall;
        drain   = (sb.size() > 0) && !miss;
        e_maddr = miss ? v.addr : ((sb.size() > 0) ? sb[0].addr : 32'd0);

        chk("mdl_stall",  32'(cpu_stall), 32'(e_stall));
        chk("mdl_mread",  32'(MEMRead),   32'(miss));
        chk("mdl_mwrite", 32'(MEMWrite),  32'(drain));
        chk("mdl_empty",  32'(empty),     32'(sb.size() == 0));
        chk("mdl_rvalid", 32'(cpu_rvalid), 32'(prev_ld));
        if (miss || drain) chk("mdl_maddr", mem_addr, e_maddr);
        if (drain)         chk("mdl_mwd", mem_wd, sb[0].data);
        if (prev_ld)       chk("mdl_rdata", cpu_rdata, prev_data);

        if (use_tbl) begin
            chk("tbl_stall",  32'(cpu_stall),  32'(v.stall));
            chk("tbl_mread",  32'(MEMRead),    32'(v.mr));
            chk("tbl_mwrite", 32'(MEMWrite),   32'(v.mw));
            chk("tbl_rvalid", 32'(cpu_rvalid), 32'(v.rv));
            chk("tbl_empty",  32'(empty),      32'(v.emp));
            if (v.mr || v.mw) chk("tbl_maddr", mem_addr, v.ma);
            if (v.mw)         chk("tbl_mwd", mem_wd, v.mwd);
            if (v.rv)         chk("tbl_rdata", cpu_rdata, v.rdat);
        end

        size_before = sb.size();
        if (drain) begin
            e = sb.pop_front();
            gmem[e.addr[31:2]] = e.data;
        end
        if (st) begin
            e.addr = v.addr; e.data = v.wd;
            sb.push_back(e);
        end
        flushing   = (flushing || (v.fl && size_before > 0)) && (sb.size() > 0);
        prev_ld    = ld;
        prev_data  = hit ? hd : memval(v.addr);
        mem_rd     = miss ? memval(v.addr) : $urandom;
        last_stall = e_stall;
    endtask

    initial begin
        vec_t v;
        int   r;
        n_tests = 0; n_fail = 0;
        rst = 1'b0; cpu_rd = 0; cpu_wr = 0; flush = 0; cpu_addr = '0; cpu_wd = '0; mem_rd = '0;
        prev_data = '0;
        model_reset();

        // Directed table: single store drain, load priority, hit handling, flush.
        tbl.push_back(mk(0,1,0,32'h40,32'h11,  0,0,0,32'h0,32'h0,    0,32'h0,1));
        tbl.push_back(mk(0,0,0,32'h0,32'h0,    0,0,1,32'h40,32'h11,  0,32'h0,0));
        tbl.push_back(mk(0,0,0,32'h0,32'h0,    0,0,0,32'h0,32'h0,    0,32'h0,1));
        tbl.push_back(mk(0,1,0,32'h200,32'h200,0,0,0,32'h0,32'h0,    0,32'h0,1));
        tbl.push_back(mk(1,0,0,32'h100,32'h0,  0,1,0,32'h100,32'h0,  0,32'h0,0));
        tbl.push_back(mk(1,0,0,32'h104,32'h0,  0,1,0,32'h104,32'h0,  1,init_val(32'h100),0));
        tbl.push_back(mk(1,0,0,32'h108,32'h0,  0,1,0,32'h108,32'h0,  1,init_val(32'h104),0));
        tbl.push_back(mk(1,0,0,32'h10C,32'h0,  0,1,0,32'h10C,32'h0,  1,init_val(32'h108),0));
        tbl.push_back(mk(0,0,0,32'h0,32'h0,    0,0,1,32'h200,32'h200,1,init_val(32'h10C),0));
        tbl.push_back(mk(0,0,0,32'h0,32'h0,    0,0,0,32'h0,32'h0,    0,32'h0,1));
        tbl.push_back(mk(0,1,0,32'h80,32'hA,   0,0,0,32'h0,32'h0,    0,32'h0,1));
        tbl.push_back(mk(0,1,0,32'h80,32'hB,   0,0,1,32'h80,32'hA,   0,32'h0,0));
`ifdef STBUF_FWD_EN
        tbl.push_back(mk(1,0,0,32'h80,32'h0,   0,0,1,32'h80,32'hB,   0,32'h0,0));
        tbl.push_back(mk(0,0,0,32'h0,32'h0,    0,0,0,32'h0,32'h0,    1,32'hB,1));
        tbl.push_back(mk(0,0,0,32'h0,32'h0,    0,0,0,32'h0,32'h0,    0,32'h0,1));
`else
        tbl.push_back(mk(1,0,0,32'h80,32'h0,   1,0,1,32'h80,32'hB,   0,32'h0,0));
        tbl.push_back(mk(1,0,0,32'h80,32'h0,   0,1,0,32'h80,32'h0,   0,32'h0,1));
        tbl.push_back(mk(0,0,0,32'h0,32'h0,    0,0,0,32'h0,32'h0,    1,32'hB,1));
`endif
        tbl.push_back(mk(0,1,0,32'h300,32'h31, 0,0,0,32'h0,32'h0,    0,32'h0,1));
        tbl.push_back(mk(1,0,1,32'h500,32'h0,  0,1,0,32'h500,32'h0,  0,32'h0,0));
        tbl.push_back(mk(0,1,0,32'h304,32'h32, 1,0,1,32'h300,32'h31, 1,init_val(32'h500),0));
        tbl.push_back(mk(0,1,0,32'h304,32'h32, 0,0,0,32'h0,32'h0,    0,32'h0,1));
        tbl.push_back(mk(0,0,0,32'h0,32'h0,    0,0,1,32'h304,32'h32, 0,32'h0,0));
        tbl.push_back(mk(0,0,1,32'h0,32'h0,    0,0,0,32'h0,32'h0,    0,32'h0,1));
        tbl.push_back(mk(1,0,0,32'h40,32'h0,   0,1,0,32'h40,32'h0,   0,32'h0,1));
        tbl.push_back(mk(0,0,0,32'h0,32'h0,    0,0,0,32'h0,32'h0,    1,32'h11,1));

        repeat (3) @(negedge clk_50);
        reset_checks("por");
        rst = 1'b1;

        foreach (tbl[i]) step(tbl[i], 1'b1);

        // Reset with a store buffered: it must be discarded, never written to memory.
        step(mk(0,1,0,32'h600,32'h66, 0,0,0,0,0,0,0,0), 1'b0);
        @(posedge clk_50); #1;
        cpu_wr = 1'b0; rst = 1'b0;
        @(negedge clk_50);
        reset_checks("rst_mid");
        model_reset();
        @(negedge clk_50);
        rst = 1'b1;
        repeat (3) step(mk(0,0,0,32'h0,32'h0, 0,0,0,0,0,0,0,0), 1'b0);
        step(mk(1,0,0,32'h600,32'h0, 0,0,0,0,0,0,0,0), 1'b0);
        step(mk(0,0,0,32'h0,32'h0, 0,0,0,0,0,0,0,0), 1'b0);
        chk("rst_discard", cpu_rdata, init_val(32'h600));

        // Random traffic over a small address window; stalled requests are held.
        v = mk(0,0,0,32'h0,32'h0, 0,0,0,0,0,0,0,0);
        for (int c = 0; c < 3000; c++) begin
            if (!last_stall) begin
                r      = $urandom_range(0, 99);
                v.rd   = (r < 35) || (r == 99);
                v.wr   = (r >= 35 && r < 75) || (r == 99);
                v.addr = 32'h1000 + 32'($urandom_range(0, 31));
                v.wd   = $urandom;
                v.fl   = ($urandom_range(0, 9) == 0);
            end
            step(v, 1'b0);
        end
        repeat (2) step(mk(0,0,0,32'h0,32'h0, 0,0,0,0,0,0,0,0), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
